// File: rtl/loopback_pkg.sv
// Shared types and widths for the loopback test sequencer.
package loopback_pkg;
  localparam int DATA_W = 8;
  localparam int ERR_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_e;
endpackage

// File: rtl/loopback_rx_checker.sv
// Compares looped-back RX bytes against a wrapping expected count and tracks
// received bytes, saturating mismatch count and RX idle time.
module loopback_rx_checker
  import loopback_pkg::*;
#(
  parameter int NUM_BYTES      = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(NUM_BYTES + 1),
  parameter int IDLE_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              idle_en,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [ERR_W-1:0]  err_count,
  output logic [IDLE_W-1:0] idle_cnt
);
  localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(NUM_BYTES);

  logic [DATA_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              rx_take;

  // Bytes beyond the expected total are not counted or checked.
  assign rx_take = enable && rx_valid && (rx_cnt_q != RX_FULL);

  always_comb begin
    exp_d       = exp_q;
    rx_cnt_d    = rx_cnt_q;
    err_count_d = err_count_q;
    idle_cnt_d  = idle_cnt_q;
    if (clear) begin
      exp_d       = '0;
      rx_cnt_d    = '0;
      err_count_d = '0;
      idle_cnt_d  = '0;
    end else if (rx_take) begin
      exp_d      = exp_q + 1'b1;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      idle_cnt_d = '0;
      if ((rx_data != exp_q) && (err_count_q != '1)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end else if (idle_en && !rx_valid) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q       <= '0;
      rx_cnt_q    <= '0;
      err_count_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      exp_q       <= exp_d;
      rx_cnt_q    <= rx_cnt_d;
      err_count_q <= err_count_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign rx_cnt    = rx_cnt_q;
  assign err_count = err_count_q;
  assign idle_cnt  = idle_cnt_q;
endmodule

// File: rtl/loopback_seq_ctrl.sv
// Sequencer for one loopback run: clears and steps the counter generator,
// streams NUM_BYTES bytes over TX and reports the RX check result.
module loopback_seq_ctrl
  import loopback_pkg::*;
#(
  parameter int NUM_BYTES      = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] gen_data,
  output logic              gen_clr,
  output logic              gen_step,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count
);
  localparam int CNT_W  = $clog2(NUM_BYTES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TX_LAST   = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0]  RX_FULL   = CNT_W'(NUM_BYTES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic             gen_clr_q, gen_clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0]  rx_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              tx_fire;

  assign tx_fire = tx_valid_q & tx_ready;

  loopback_rx_checker #(
    .NUM_BYTES      (NUM_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W),
    .IDLE_W         (IDLE_W)
  ) u_rx_checker (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == CLEAR),
    .enable    ((state_q == RUN) || (state_q == DRAIN)),
    .idle_en   (state_q == DRAIN),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_cnt    (rx_cnt),
    .err_count (err_count),
    .idle_cnt  (idle_cnt)
  );

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    timeout_d = timeout_q;
    pass_d    = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        state_d   = RUN;
        tx_cnt_d  = '0;
        timeout_d = 1'b0;
      end
      RUN: begin
        if (tx_fire) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
          if (tx_cnt_q == TX_LAST) state_d = DRAIN;
        end
      end
      // A byte arriving on the last idle cycle resets the timer, so it wins.
      DRAIN: begin
        if (rx_cnt == RX_FULL) begin
          state_d = DONE;
        end else if ((idle_cnt == IDLE_LAST) && !rx_valid) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE:    if (start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      if (state_q != CLEAR) timeout_d = timeout_q;
    end

    tx_valid_d = (state_d == RUN);
    gen_clr_d  = (state_d == CLEAR);
    busy_d     = state_d inside {CLEAR, RUN, DRAIN};
    done_d     = (state_d == DONE);
    // Result is captured once on entry to DONE and held there.
    if (state_d == DONE) begin
      pass_d = (state_q == DONE) ? pass_q
             : ((err_count == '0) && !timeout_d && (rx_cnt == RX_FULL));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
      gen_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_valid_q <= tx_valid_d;
      gen_clr_q  <= gen_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_valid_q ? gen_data : '0;
  assign gen_step = tx_fire;
  assign gen_clr  = gen_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
endmodule

// File: tb/tb_loopback_seq_ctrl.sv
// Directed bench: a 4-byte instance with a corruptible/droppable 3-cycle
// loopback, and a 300-byte instance for the generator wrap.
module tb_loopback_seq_ctrl;
  logic clk = 1'b0;
  logic reset, start, abort, tx_ready;
  logic start_b;
  logic tx_ready_b = 1'b1;
  logic abort_b = 1'b0;

  logic [7:0]  gen_a = 8'h00, txd_a, rxd_a;
  logic        gen_clr_a, gen_step_a, tx_valid_a, busy_a, done_a, pass_a, timeout_a;
  logic [15:0] err_a;
  logic [7:0]  gen_b = 8'h00, txd_b, rxd_b;
  logic        gen_clr_b, gen_step_b, tx_valid_b, busy_b, done_b, pass_b, timeout_b;
  logic [15:0] err_b;

  logic [2:0]  dv_a = 3'b000, dv_b = 3'b000;
  logic [7:0]  d0_a = 0, d1_a = 0, d2_a = 0, d0_b = 0, d1_b = 0, d2_b = 0;
  logic [31:0] corrupt_mask = 0, drop_mask = 0;
  int          tx_idx_a = 0;
  int          edge_cnt = 0;
  int          n_pass = 0, n_total = 0;

  logic [7:0] acc_q[$];
  int  step_cnt, data_changed, last_rx_edge, done_edge, latency;
  bit  finished, saw_clr, prev_stalled;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  loopback_seq_ctrl #(.NUM_BYTES(4), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .gen_data(gen_a),
    .gen_clr(gen_clr_a), .gen_step(gen_step_a), .tx_data(txd_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready), .rx_data(rxd_a), .rx_valid(dv_a[2]), .busy(busy_a), .done(done_a),
    .pass(pass_a), .timeout(timeout_a), .err_count(err_a)
  );

  loopback_seq_ctrl #(.NUM_BYTES(300), .TIMEOUT_CYCLES(1024)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .gen_data(gen_b),
    .gen_clr(gen_clr_b), .gen_step(gen_step_b), .tx_data(txd_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_data(rxd_b), .rx_valid(dv_b[2]), .busy(busy_b), .done(done_b),
    .pass(pass_b), .timeout(timeout_b), .err_count(err_b)
  );

  assign rxd_a = d2_a;
  assign rxd_b = d2_b;

  // Counter generators and 3-cycle loopback delay lines
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (gen_clr_a) gen_a <= 8'h00; else if (gen_step_a) gen_a <= gen_a + 8'h01;
    if (gen_clr_b) gen_b <= 8'h00; else if (gen_step_b) gen_b <= gen_b + 8'h01;
    if (gen_clr_a) tx_idx_a <= 0; else if (gen_step_a) tx_idx_a <= tx_idx_a + 1;
    dv_a <= {dv_a[1:0], gen_step_a && !drop_mask[tx_idx_a[4:0]]};
    d0_a <= txd_a ^ (corrupt_mask[tx_idx_a[4:0]] ? 8'h10 : 8'h00);
    d1_a <= d0_a;
    d2_a <= d1_a;
    dv_b <= {dv_b[1:0], gen_step_b};
    d0_b <= txd_b;
    d1_b <= d0_b;
    d2_b <= d1_b;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one start..DONE sequence on dut_a, recording what was sent.
  task run_a(input bit stall, input int budget);
    acc_q.delete();
    step_cnt = 0; data_changed = 0; finished = 0; prev_stalled = 0; prev_data = 8'h00;
    last_rx_edge = -1; done_edge = -1; latency = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    saw_clr = gen_clr_a;
    for (int c = 0; c < budget; c++) begin
      if (done_a) begin
        finished = 1;
        done_edge = edge_cnt;
        break;
      end
      tx_ready = stall ? (c % 3 == 2) : 1'b1;
      #1;
      if (tx_valid_a && latency < 0) latency = c + 1;
      if (prev_stalled && tx_valid_a && (txd_a !== prev_data)) data_changed++;
      prev_stalled = tx_valid_a && !tx_ready;
      prev_data = txd_a;
      if (gen_step_a) begin
        step_cnt++;
        acc_q.push_back(txd_a);
      end
      if (dv_a[2]) last_rx_edge = edge_cnt + 1;
      tick();
    end
    tx_ready = 1'b1;
  endtask

  task test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1; start_b = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({busy_a, done_a, pass_a, timeout_a, tx_valid_a, gen_clr_a, gen_step_a} !== 7'b0) begin
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {busy_a, done_a, pass_a, timeout_a, tx_valid_a, gen_clr_a, gen_step_a});
    end else n_pass++;
    n_total++;
    if ({err_a, txd_a} !== 24'h0) $display("[TB] FAIL reset_data: got %h expected 000000", {err_a, txd_a});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if (busy_a !== 1'b0) $display("[TB] FAIL idle_busy: got %b expected 0", busy_a);
    else n_pass++;
  endtask

  task test_basic;
    run_a(1'b0, 40);
    n_total++;
    if (!finished) $display("[TB] FAIL basic_finish: got no done expected done within 40 cycles");
    else n_pass++;
    n_total++;
    if (saw_clr !== 1'b1) $display("[TB] FAIL basic_gen_clr: got %b expected 1", saw_clr);
    else n_pass++;
    n_total++;
    if (latency != 2) $display("[TB] FAIL basic_latency: got %0d expected 2", latency);
    else n_pass++;
    n_total++;
    if (acc_q.size() != 4) $display("[TB] FAIL basic_count: got %0d expected 4", acc_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      got = (i < acc_q.size()) ? acc_q[i] : 8'hEE;
      n_total++;
      if (got !== 8'(i)) $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, got, 8'(i));
      else n_pass++;
    end
    n_total++;
    if ({done_a, pass_a, timeout_a, err_a} !== {3'b110, 16'h0000}) begin
      $display("[TB] FAIL basic_result: got done=%b pass=%b timeout=%b err=%0d expected 1 1 0 0",
               done_a, pass_a, timeout_a, err_a);
    end else n_pass++;
  endtask

  task test_stall;
    run_a(1'b1, 80);
    n_total++;
    if (!finished) $display("[TB] FAIL stall_finish: got no done expected done within 80 cycles");
    else n_pass++;
    n_total++;
    if (step_cnt != 4) $display("[TB] FAIL stall_steps: got %0d expected 4", step_cnt);
    else n_pass++;
    n_total++;
    if (data_changed != 0) $display("[TB] FAIL stall_stable: got %0d changes expected 0", data_changed);
    else n_pass++;
    n_total++;
    if (acc_q.size() != 4 || acc_q[3] !== 8'h03) $display("[TB] FAIL stall_last: got size %0d expected 4 ending 03", acc_q.size());
    else n_pass++;
    n_total++;
    if (pass_a !== 1'b1) $display("[TB] FAIL stall_pass: got %b expected 1", pass_a);
    else n_pass++;
  endtask

  task test_corrupt;
    corrupt_mask = 32'hC;
    run_a(1'b0, 40);
    corrupt_mask = 32'h0;
    n_total++;
    if (!finished) $display("[TB] FAIL corrupt_finish: got no done expected done within 40 cycles");
    else n_pass++;
    n_total++;
    if (err_a !== 16'd2) $display("[TB] FAIL corrupt_err: got %0d expected 2", err_a);
    else n_pass++;
    n_total++;
    if ({pass_a, timeout_a} !== 2'b00) $display("[TB] FAIL corrupt_pass: got pass=%b timeout=%b expected 0 0", pass_a, timeout_a);
    else n_pass++;
  endtask

  task test_abort;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++;
    if ({done_a, pass_a, busy_a} !== 3'b000) $display("[TB] FAIL abort_done: got %b expected 000", {done_a, pass_a, busy_a});
    else n_pass++;
    n_total++;
    if (err_a !== 16'd2) $display("[TB] FAIL abort_err_kept: got %0d expected 2", err_a);
    else n_pass++;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    n_total++;
    if ({tx_valid_a, gen_clr_a, busy_a} !== 3'b101) $display("[TB] FAIL busy_start_ignored: got %b expected 101", {tx_valid_a, gen_clr_a, busy_a});
    else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_total++;
    if ({tx_valid_a, busy_a, done_a, gen_step_a} !== 4'b0000) $display("[TB] FAIL abort_run: got %b expected 0000", {tx_valid_a, busy_a, done_a, gen_step_a});
    else n_pass++;
    repeat (6) tick();
    run_a(1'b0, 40);
    n_total++;
    if (saw_clr !== 1'b1) $display("[TB] FAIL rerun_gen_clr: got %b expected 1", saw_clr);
    else n_pass++;
    n_total++;
    if (!finished || pass_a !== 1'b1 || err_a !== 16'd0) $display("[TB] FAIL rerun_pass: got done=%b pass=%b err=%0d expected 1 1 0", finished, pass_a, err_a);
    else n_pass++;
    n_total++;
    if (acc_q.size() == 0 || acc_q[0] !== 8'h00) $display("[TB] FAIL rerun_first: got size %0d expected first byte 00", acc_q.size());
    else n_pass++;
  endtask

  task test_timeout;
    drop_mask = 32'h8;
    run_a(1'b0, 60);
    drop_mask = 32'h0;
    n_total++;
    if (!finished) $display("[TB] FAIL timeout_finish: got no done expected done within 60 cycles");
    else n_pass++;
    n_total++;
    if ({timeout_a, pass_a} !== 2'b10) $display("[TB] FAIL timeout_flags: got timeout=%b pass=%b expected 1 0", timeout_a, pass_a);
    else n_pass++;
    n_total++;
    if (done_edge - last_rx_edge != 16) $display("[TB] FAIL timeout_delay: got %0d expected 16", done_edge - last_rx_edge);
    else n_pass++;
    n_total++;
    if (dut_a.rx_cnt !== 3'd3) $display("[TB] FAIL timeout_rx_cnt: got %0d expected 3", dut_a.rx_cnt);
    else n_pass++;
  endtask

  task test_wrap;
    int steps;
    bit fin;
    logic [7:0] last_b, b255, b256;
    steps = 0; fin = 0; last_b = 8'h55; b255 = 8'h55; b256 = 8'h55;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int c = 0; c < 700; c++) begin
      if (done_b) begin
        fin = 1;
        break;
      end
      if (gen_step_b) begin
        if (steps == 255) b255 = txd_b;
        if (steps == 256) b256 = txd_b;
        last_b = txd_b;
        steps++;
      end
      tick();
    end
    n_total++;
    if (!fin || steps != 300) $display("[TB] FAIL wrap_count: got done=%b steps=%0d expected 1 300", fin, steps);
    else n_pass++;
    n_total++;
    if ({b255, b256} !== 16'hFF00) $display("[TB] FAIL wrap_edge: got %h %h expected ff 00", b255, b256);
    else n_pass++;
    n_total++;
    if (last_b !== 8'h2B) $display("[TB] FAIL wrap_last: got %h expected 2b", last_b);
    else n_pass++;
    n_total++;
    if ({pass_b, timeout_b, err_b} !== {2'b10, 16'h0000}) $display("[TB] FAIL wrap_result: got pass=%b timeout=%b err=%0d expected 1 0 0", pass_b, timeout_b, err_b);
    else n_pass++;
  endtask

  task test_reset_in_drain;
    bit in_drain;
    in_drain = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy_a && !tx_valid_a && !gen_clr_a) begin
        in_drain = 1;
        break;
      end
      tick();
    end
    n_total++;
    if (!in_drain) $display("[TB] FAIL drain_reached: got no drain expected drain within 20 cycles");
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({busy_a, done_a, pass_a, timeout_a, tx_valid_a, gen_clr_a, gen_step_a} !== 7'b0) begin
      $display("[TB] FAIL drain_reset_flags: got %b expected 0000000",
               {busy_a, done_a, pass_a, timeout_a, tx_valid_a, gen_clr_a, gen_step_a});
    end else n_pass++;
    n_total++;
    if ({err_a, txd_a} !== 24'h0) $display("[TB] FAIL drain_reset_data: got %h expected 000000", {err_a, txd_a});
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_corrupt();
    test_abort();
    test_timeout();
    test_wrap();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/loopback_seq_ctrl.md
Name: loopback_seq_ctrl

Overview:
Sequencer for one loopback test run. It clears and steps the 8-bit counter data generator, which wraps from 0xFF to 0x00, and streams NUM_BYTES generator bytes out over a valid/ready TX interface. It checks the looped-back RX bytes against an internally tracked expected count and reports done, pass, error count and timeout. It sits between the test start/status registers and the counter generator plus the TX/RX loopback path.

Parameters:
NUM_BYTES, 256, bytes sent per run (1..65535)
TIMEOUT_CYCLES, 1024, RX idle cycles tolerated before the run is aborted (>=2)
CNT_W, $clog2(NUM_BYTES+1), width of the tx/rx byte counters (derived, localparam)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; starts a run from IDLE or DONE
abort  in  1  synchronous abort; any state -> IDLE
gen_data  in  8  current generator count
gen_clr  out  1  synchronous clear to the generator
gen_step  out  1  advance the generator by one
tx_data  out  8  byte to loopback TX
tx_valid  out  1  TX data valid
tx_ready  in  1  TX accepts the byte
rx_data  in  8  looped-back byte
rx_valid  in  1  RX byte valid (no backpressure)
busy  out  1  high in CLEAR/RUN/DRAIN
done  out  1  high while in DONE
pass  out  1  result valid in DONE
timeout  out  1  run ended by RX timeout
err_count  out  16  mismatch count, saturating

Behaviour:
- Reset state: IDLE.
- Reset values: all outputs 0; internal tx_cnt, rx_cnt, exp, idle_cnt all 0.
- State IDLE:
  - start -> CLEAR.
  - rx_valid is ignored.
- State CLEAR (exactly 1 cycle):
  - gen_clr=1.
  - tx_cnt, rx_cnt, exp, idle_cnt, err_count and timeout all cleared.
  - Next state RUN.
- State RUN:
  - tx_valid=1 and tx_data=gen_data, combinational pass-through.
  - On tx_valid&tx_ready: gen_step=1 and tx_cnt++.
  - When tx_cnt==NUM_BYTES-1 and the byte is accepted -> DRAIN; tx_valid drops the next cycle.
  - tx_valid stays high while tx_ready is low. tx_data must stay stable because the generator only steps on acceptance.
- RX check, active in RUN and DRAIN:
  - On each rx_valid: compare rx_data with exp, then exp++ (8-bit wrap 0xFF->0x00), rx_cnt++, idle_cnt cleared.
  - On mismatch: err_count++, saturating at 0xFFFF.
  - rx_valid arriving after rx_cnt==NUM_BYTES is ignored.
- Idle timer:
  - idle_cnt++ in DRAIN on every cycle without rx_valid.
  - In RUN, idle_cnt holds at 0.
- State DRAIN:
  - rx_cnt==NUM_BYTES -> DONE.
  - Otherwise, idle_cnt==TIMEOUT_CYCLES-1 with no rx_valid that cycle -> DONE, with timeout=1.
  - If a final byte and the timeout occur in the same cycle, the byte wins: it is counted and checked, and timeout=0.
- State DONE:
  - done=1.
  - pass = (err_count==0) & ~timeout & (rx_cnt==NUM_BYTES), registered on DONE entry.
  - Results hold until start (-> CLEAR) or abort (-> IDLE).
- abort:
  - Has priority over start and over every transition; goes to IDLE in 1 cycle.
  - Drops tx_valid, busy, done and pass.
  - err_count and timeout keep their values until the next CLEAR.
- start while busy is ignored.
- Asserting reset mid-run forces IDLE immediately, asynchronously, and all outputs return to 0.
- Latency: start to first tx_valid is 2 cycles (CLEAR, then RUN).

Decomposition:
- Package loopback_pkg:
  - state enum: IDLE, CLEAR, RUN, DRAIN, DONE
  - ERR_W=16
  - DATA_W=8
- Natural sub-module: loopback_rx_checker.
  - Contains exp, rx_cnt, err_count and idle_cnt.
  - Has an enable input and a clear input.
- The FSM and TX side stay in the top-level module.

Test Plan:
- NUM_BYTES=4, tx_ready=1, rx equals tx delayed 3 cycles -> tx_data 00,01,02,03; done=1, pass=1, err_count=0, timeout=0.
- NUM_BYTES=300, wrap test -> exp wraps 0xFF->0x00; final tx byte 0x2B; pass=1.
- tx_ready toggling 1-of-3 cycles -> tx_data stable while stalled; gen_step pulses exactly 4 times for NUM_BYTES=4; pass=1.
- Corrupt byte 2 (0x02->0x12) and byte 3 -> err_count=2, pass=0.
- Drop the last RX byte, TIMEOUT_CYCLES=16 -> DONE 16 cycles after the last rx_valid; timeout=1, pass=0, rx_cnt=3.
- Edge cases:
  - abort mid-RUN, then start -> gen_clr pulses, counters reset, second run passes.
  - reset asserted in DRAIN -> all outputs 0 immediately.
